// File: rtl/health_tracker_pkg.sv
// Shared types and constants for the game's health/collision logic.
// Imported by the tracker, its sub-module and the bench.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ALIVE  = 2'd1,
      INVULN = 2'd2,
      DEAD   = 2'd3
   } health_state_t;

   localparam logic [1:0] MAX_HEALTH_C    = 2'd3;
   localparam logic [7:0] INVULN_FRAMES_C = 8'd60;
   localparam logic [3:0] BLINK_FRAMES_C  = 4'd4;

   function automatic logic [1:0] sat_dec2(input logic [1:0] v);
      return (v == 2'd0) ? 2'd0 : v - 2'd1;
   endfunction

endpackage

// File: rtl/health_tracker_if.sv
// Pixel-flag inputs and health outputs exchanged between the colour mapper/game FSM and
// the health tracker. master drives the flags; slave is the tracker.
interface health_tracker_if;

   logic       playerFlag;
   logic       ball_on;
   logic       obstacle_on;
   logic       pit_on;
   logic       collisionFlag;
   logic [1:0] healthbar;
   logic       invuln;
   logic       blink;
   logic       hit_pulse;

   modport master (
      output playerFlag, ball_on, obstacle_on, pit_on,
      input  collisionFlag, healthbar, invuln, blink, hit_pulse
   );

   modport slave (
      input  playerFlag, ball_on, obstacle_on, pit_on,
      output collisionFlag, healthbar, invuln, blink, hit_pulse
   );

endinterface

// File: rtl/frame_edge_sync.sv
// Brings an asynchronous frame strobe into the clk_i domain and emits a one-cycle pulse
// on each rising edge.
module frame_edge_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic rise_o
);

   logic f1_q, f2_q, f3_q;
   logic f1_d, f2_d, f3_d;

   always_comb begin
      f1_d = async_i;
      f2_d = f1_q;
      f3_d = f2_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         f1_q <= 1'b0;
         f2_q <= 1'b0;
         f3_q <= 1'b0;
      end else begin
         f1_q <= f1_d;
         f2_q <= f2_d;
         f3_q <= f3_d;
      end
   end

   assign rise_o = f2_q & ~f3_q;

endmodule

// File: rtl/health_tracker.sv
// Tracks player health from ball/hazard pixel overlaps, deciding damage once per frame and
// running invulnerability frames with sprite blink after a non-fatal hit.
module health_tracker
   import game_pkg::*;
#(
   parameter logic [1:0] MAX_HEALTH    = MAX_HEALTH_C,
   parameter logic [7:0] INVULN_FRAMES = INVULN_FRAMES_C,
   parameter logic [3:0] BLINK_FRAMES  = BLINK_FRAMES_C
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    frame_clk,
   health_tracker_if.slave         bus
);

   logic frame_rise;

   frame_edge_sync u_frame_sync (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .async_i (frame_clk),
      .rise_o  (frame_rise)
   );

   health_state_t state_q, state_d;
   logic [1:0]    health_q, health_d;
   logic [7:0]    inv_cnt_q, inv_cnt_d;
   logic [3:0]    blink_cnt_q, blink_cnt_d;
   logic          blink_q, blink_d;
   logic          hit_pulse_q, hit_pulse_d;
   logic          hit_pend_q, hit_pend_d;
   logic          fatal_pend_q, fatal_pend_d;

   logic hit_set, fatal_set;

   assign hit_set   = bus.ball_on & bus.obstacle_on & bus.playerFlag;
   assign fatal_set = bus.ball_on & bus.pit_on & bus.playerFlag;

   // Overlaps seen in the frame_rise cycle itself are carried into the next frame.
   always_comb begin
      hit_pend_d   = frame_rise ? hit_set   : (hit_pend_q | hit_set);
      fatal_pend_d = frame_rise ? fatal_set : (fatal_pend_q | fatal_set);
      if (!bus.playerFlag) begin
         hit_pend_d   = 1'b0;
         fatal_pend_d = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      health_d    = health_q;
      inv_cnt_d   = inv_cnt_q;
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      hit_pulse_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            health_d = MAX_HEALTH;
            if (bus.playerFlag) state_d = ALIVE;
         end
         ALIVE: begin
            if (frame_rise) begin
               if (fatal_pend_q) begin
                  state_d  = DEAD;
                  health_d = 2'd0;
               end else if (hit_pend_q) begin
                  hit_pulse_d = 1'b1;
                  if (health_q <= 2'd1) begin
                     state_d  = DEAD;
                     health_d = 2'd0;
                  end else begin
                     state_d     = INVULN;
                     health_d    = sat_dec2(health_q);
                     inv_cnt_d   = INVULN_FRAMES;
                     blink_cnt_d = BLINK_FRAMES;
                     blink_d     = 1'b0;
                  end
               end
            end
         end
         INVULN: begin
            if (frame_rise) begin
               if (fatal_pend_q) begin
                  state_d  = DEAD;
                  health_d = 2'd0;
               end else begin
                  inv_cnt_d = (inv_cnt_q == 8'd0) ? 8'd0 : inv_cnt_q - 8'd1;
                  if (inv_cnt_q <= 8'd1) begin
                     state_d = ALIVE;
                  end else if (blink_cnt_q <= 4'd1) begin
                     blink_d     = ~blink_q;
                     blink_cnt_d = BLINK_FRAMES;
                  end else begin
                     blink_cnt_d = blink_cnt_q - 4'd1;
                  end
               end
            end
         end
         DEAD: begin
            health_d = 2'd0;
         end
         default: state_d = IDLE;
      endcase

      // Leaving the game aborts any state, including a pending frame decision.
      if (!bus.playerFlag) begin
         state_d     = IDLE;
         health_d    = MAX_HEALTH;
         inv_cnt_d   = 8'd0;
         blink_cnt_d = 4'd0;
         hit_pulse_d = 1'b0;
      end

      if (state_d != INVULN) blink_d = 1'b0;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= IDLE;
         health_q     <= MAX_HEALTH;
         inv_cnt_q    <= 8'd0;
         blink_cnt_q  <= 4'd0;
         blink_q      <= 1'b0;
         hit_pulse_q  <= 1'b0;
         hit_pend_q   <= 1'b0;
         fatal_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         health_q     <= health_d;
         inv_cnt_q    <= inv_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_q      <= blink_d;
         hit_pulse_q  <= hit_pulse_d;
         hit_pend_q   <= hit_pend_d;
         fatal_pend_q <= fatal_pend_d;
      end
   end

   assign bus.collisionFlag = (state_q == DEAD);
   assign bus.invuln        = (state_q == INVULN);
   assign bus.healthbar     = health_q;
   assign bus.blink         = blink_q;
   assign bus.hit_pulse     = hit_pulse_q;

endmodule

// File: tb/tb_health_tracker.sv
// Directed bench for health_tracker: frame-by-frame stimulus with hand-computed
// health, death, invulnerability, blink and hit-pulse expectations.
module tb_health_tracker;

   logic clk = 1'b0;
   logic reset;
   logic frame_clk;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   pulse_cnt = 0;
   int   base;
   logic last_pulse;

   always #5 clk = ~clk;

   health_tracker_if bus ();

   health_tracker dut (
      .Clk       (clk),
      .Reset     (reset),
      .frame_clk (frame_clk),
      .bus       (bus)
   );

   always @(negedge clk) if (bus.hit_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One frame: strobe frame_clk, wait until the decision is visible, then one overlap cycle.
   task automatic run_frame(input logic obs, input logic pit);
      @(negedge clk);
      frame_clk = 1'b1;
      repeat (3) @(negedge clk);
      last_pulse = bus.hit_pulse;
      frame_clk = 1'b0;
      bus.ball_on     = obs | pit;
      bus.obstacle_on = obs;
      bus.pit_on      = pit;
      @(negedge clk);
      bus.ball_on     = 1'b0;
      bus.obstacle_on = 1'b0;
      bus.pit_on      = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset           = 1'b1;
      frame_clk       = 1'b0;
      bus.playerFlag  = 1'b0;
      bus.ball_on     = 1'b0;
      bus.obstacle_on = 1'b0;
      bus.pit_on      = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic start_play();
      @(negedge clk);
      bus.playerFlag = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      do_reset();
      check_eq("rst_health", bus.healthbar, 3);
      check_eq("rst_coll", bus.collisionFlag, 0);
      check_eq("rst_invuln", bus.invuln, 0);
      check_eq("rst_blink", bus.blink, 0);
      check_eq("rst_pulse", bus.hit_pulse, 0);

      // 1: five clean frames
      start_play();
      base = pulse_cnt;
      repeat (5) run_frame(1'b0, 1'b0);
      check_eq("t1_health", bus.healthbar, 3);
      check_eq("t1_coll", bus.collisionFlag, 0);
      check_eq("t1_invuln", bus.invuln, 0);
      check_eq("t1_pulses", pulse_cnt - base, 0);

      // 2: single hit, then invulnerability with blink
      base = pulse_cnt;
      run_frame(1'b1, 1'b0);
      run_frame(1'b0, 1'b0);
      check_eq("t2_health", bus.healthbar, 2);
      check_eq("t2_pulse_now", last_pulse, 1);
      check_eq("t2_invuln", bus.invuln, 1);
      check_eq("t2_blink0", bus.blink, 0);
      repeat (3) run_frame(1'b0, 1'b0);
      check_eq("t2_pulse_width", pulse_cnt - base, 1);
      check_eq("t2_blink3", bus.blink, 0);
      run_frame(1'b0, 1'b0);
      check_eq("t2_blink4", bus.blink, 1);
      repeat (4) run_frame(1'b0, 1'b0);
      check_eq("t2_blink8", bus.blink, 0);
      repeat (51) run_frame(1'b0, 1'b0);
      check_eq("t2_invuln59", bus.invuln, 1);
      run_frame(1'b0, 1'b0);
      check_eq("t2_invuln60", bus.invuln, 0);
      check_eq("t2_blink60", bus.blink, 0);
      check_eq("t2_health60", bus.healthbar, 2);

      // 3: overlap every frame for 200 frames
      do_reset();
      start_play();
      base = pulse_cnt;
      for (int i = 0; i < 200; i++) begin
         run_frame(1'b1, 1'b0);
         case (i)
            0: check_eq("t3_f0_health", bus.healthbar, 3);
            1: begin
               check_eq("t3_f1_health", bus.healthbar, 2);
               check_eq("t3_f1_pulse", last_pulse, 1);
            end
            61: begin
               check_eq("t3_f61_health", bus.healthbar, 2);
               check_eq("t3_f61_invuln", bus.invuln, 0);
               check_eq("t3_f61_pulse", last_pulse, 0);
            end
            62: check_eq("t3_f62_health", bus.healthbar, 1);
            122: check_eq("t3_f122_coll", bus.collisionFlag, 0);
            123: begin
               check_eq("t3_f123_health", bus.healthbar, 0);
               check_eq("t3_f123_coll", bus.collisionFlag, 1);
               check_eq("t3_f123_pulse", last_pulse, 1);
            end
            default: ;
         endcase
      end
      check_eq("t3_end_health", bus.healthbar, 0);
      check_eq("t3_end_coll", bus.collisionFlag, 1);
      check_eq("t3_pulses", pulse_cnt - base, 3);

      // 4: pit while invulnerable
      do_reset();
      start_play();
      run_frame(1'b1, 1'b0);
      run_frame(1'b0, 1'b1);
      check_eq("t4_pre_health", bus.healthbar, 2);
      base = pulse_cnt;
      run_frame(1'b0, 1'b0);
      check_eq("t4_health", bus.healthbar, 0);
      check_eq("t4_coll", bus.collisionFlag, 1);
      check_eq("t4_invuln", bus.invuln, 0);
      check_eq("t4_pulses", pulse_cnt - base, 0);

      // 5: hit and pit in the same frame from ALIVE
      do_reset();
      start_play();
      base = pulse_cnt;
      run_frame(1'b1, 1'b1);
      run_frame(1'b0, 1'b0);
      check_eq("t5_health", bus.healthbar, 0);
      check_eq("t5_coll", bus.collisionFlag, 1);
      check_eq("t5_pulses", pulse_cnt - base, 0);

      // 6: reset mid-INVULN, then playerFlag drop from DEAD
      do_reset();
      start_play();
      run_frame(1'b1, 1'b0);
      run_frame(1'b0, 1'b0);
      repeat (30) run_frame(1'b0, 1'b0);
      check_eq("t6_pre_invuln", bus.invuln, 1);
      check_eq("t6_pre_blink", bus.blink, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("t6_rst_health", bus.healthbar, 3);
      check_eq("t6_rst_invuln", bus.invuln, 0);
      check_eq("t6_rst_blink", bus.blink, 0);
      check_eq("t6_rst_coll", bus.collisionFlag, 0);
      reset = 1'b0;
      @(negedge clk);
      run_frame(1'b0, 1'b1);
      run_frame(1'b0, 1'b0);
      check_eq("t6_dead_coll", bus.collisionFlag, 1);
      bus.playerFlag = 1'b0;
      @(negedge clk);
      check_eq("t6_idle_health", bus.healthbar, 3);
      check_eq("t6_idle_coll", bus.collisionFlag, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/health_tracker.md
Name: health_tracker

Overview:
- Producer side of the game FSM's collision/health interface. Generates the `collisionFlag` and `healthbar` signals that the game FSM consumes.
- Watches per-pixel overlap between the ball sprite and hazard layers during each video frame. At every frame boundary it decides whether damage occurs, applies invulnerability frames after a hit, and drives sprite blink.
- Sits between the colour-mapper pixel flags and the game FSM, in the `Clk` domain.

Parameters:
- MAX_HEALTH, 3: health reloaded on start; must fit in 2 bits.
- INVULN_FRAMES, 60: frames of damage immunity after a non-fatal hit (1..255).
- BLINK_FRAMES, 4: frames per blink half-period while invulnerable (1..15).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  vsync-derived frame strobe; asynchronous level, sampled in the Clk domain.
- playerFlag  in  1  game FSM in the Game state; 0 = not playing.
- ball_on  in  1  current pixel belongs to the ball sprite.
- obstacle_on  in  1  current pixel belongs to a damaging obstacle.
- pit_on  in  1  current pixel belongs to a fatal hazard.
- collisionFlag  out  1  player dead; level signal to the game FSM.
- healthbar  out  2  remaining health, 0..MAX_HEALTH.
- invuln  out  1  currently immune to damage.
- blink  out  1  ball-hide strobe for the renderer.
- hit_pulse  out  1  one-cycle pulse on each applied hit (sound/score hook).

Behaviour:
- frame_clk handling:
  - Synchronised through 2 flops (f1, f2), plus f3 for edge detect.
  - `frame_rise = f2 & ~f3`, one cycle wide.
- Reset, synchronous, dominates everything:
  - State IDLE, healthbar = MAX_HEALTH.
  - collisionFlag = 0, invuln = 0, blink = 0, hit_pulse = 0.
  - Counters = 0, pending flags = 0, sync flops = 0.
- Pending flags:
  - `hit_pend` sets when ball_on & obstacle_on & playerFlag.
  - `fatal_pend` sets when ball_on & pit_on & playerFlag.
  - Both are sticky until a frame_rise cycle. In that cycle they are consumed and cleared.
  - An overlap seen in the frame_rise cycle itself belongs to the next frame.
- All decisions are made only in frame_rise cycles. Outputs are registered and change on the Clk edge that ends the frame_rise cycle, i.e. 1-cycle latency.
- State machine, states {IDLE, ALIVE, INVULN, DEAD}:
  - IDLE:
    - healthbar = MAX_HEALTH, collisionFlag = 0.
    - playerFlag = 1 -> ALIVE on the next Clk, without waiting for a frame edge.
  - ALIVE, at frame_rise:
    - fatal_pend -> DEAD, healthbar = 0.
    - Otherwise, hit_pend with healthbar = 1 -> DEAD, healthbar = 0.
    - Otherwise, hit_pend -> healthbar - 1, INVULN, inv_cnt = INVULN_FRAMES, hit_pulse = 1.
  - INVULN:
    - hit_pend is ignored.
    - fatal_pend still kills -> DEAD, healthbar = 0.
    - Each frame_rise decrements inv_cnt. When inv_cnt reaches 0 -> ALIVE.
    - A hit pending in the expiry frame is ignored.
  - DEAD:
    - collisionFlag = 1, held.
    - Leaves only on Reset, or on playerFlag = 0 -> IDLE.
- playerFlag = 0 in any state -> IDLE next cycle, with health reload. Mid-INVULN this aborts cleanly.
- Simultaneous events:
  - fatal beats hit.
  - Reset beats everything.
  - playerFlag = 0 beats frame_rise.
- hit_pulse:
  - Asserted for the single cycle after an applied non-fatal hit.
  - Also asserted on the transition to DEAD when that transition was caused by a hit (not by a pit).
- invuln = (state == INVULN).
- blink:
  - Toggles every BLINK_FRAMES frame_rises while in INVULN.
  - Forced to 0 outside INVULN.
  - Blink counter reloads on INVULN entry.
- Widths:
  - healthbar never underflows; saturating logic is required.
  - inv_cnt is 8 bits; the blink counter is 4 bits.

Decomposition:
- Package `game_pkg`:
  - `health_state_t` enum {IDLE, ALIVE, INVULN, DEAD} (logic [1:0]).
  - Constants MAX_HEALTH_C = 2'd3, INVULN_FRAMES_C = 8'd60.
- One sub-module, `frame_edge_sync`:
  - Three-flop synchroniser plus rising-edge detector.
  - Also reusable by ball/scroll logic.

Test Plan:
1. Reset, then playerFlag = 1 with no overlap for 5 frames -> healthbar = 3, collisionFlag = 0, state ALIVE, hit_pulse never asserted.
2. One cycle of ball_on & obstacle_on in frame 1 -> at frame 2 rise +1 cycle: healthbar = 2, hit_pulse for 1 cycle, invuln = 1, blink toggles every 4 frames. After 60 frames: invuln = 0, blink = 0.
3. Continuous obstacle overlap for 200 frames -> healthbar 3->2 at frame 1, 2->1 at frame 62, then 1->0 with collisionFlag = 1 at frame 123. No further change.
4. pit_on & ball_on while INVULN with healthbar = 2 -> next frame_rise: healthbar = 0, collisionFlag = 1, no hit_pulse.
5. hit_pend and fatal_pend in the same frame from ALIVE -> DEAD; fatal wins.
6. Reset asserted mid-INVULN (inv_cnt = 30) -> next cycle healthbar = 3, invuln = 0, blink = 0, collisionFlag = 0, IDLE. Separately, playerFlag = 0 in DEAD -> IDLE with healthbar = 3.
